replica_unloader: RTL and testbench

REPLICA_UNLOADER -- requirements
Module: replica_unloader

---
 rtl/replica_unloader.sv | 157 +++++++++++++++
 tb/tb_replica_unloader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_unloader.sv
// Buffers the chain-end words of an annealing shift-out, tags each with its city
// position and replica index, and streams them to a ready/valid consumer.
//
// state | meaning
// IDLE  | waiting for start
// CAPT  | counting chain-end words and pushing them into the FIFO
// DRAIN | capture complete, emptying the FIFO
// DONE  | one-cycle completion pulse
module replica_unloader #(
    parameter int LANES       = 8,
    parameter int LANE_W      = 7,
    parameter int CITY_NUM    = 16,
    parameter int REPLICA_NUM = 4,
    parameter int FIFO_DEPTH  = 16,
    localparam int RW = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_last,
    output logic [RW-1:0]           out_replica,
    output logic                    busy,
    output logic                    done,
    output logic                    err_ovf,
    output logic                    err_extra
);

    localparam int DW    = LANES * LANE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int WW    = (CITY_NUM > 1) ? $clog2(CITY_NUM) : 1;
    localparam int TOTAL = REPLICA_NUM * CITY_NUM;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] TOTAL_M1 = CW'(TOTAL - 1);
    localparam logic [CW:0]   TOTAL_X  = (CW + 1)'(TOTAL);
    localparam logic [WW-1:0] W_LAST   = WW'(CITY_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [RW-1:0] mem_rep  [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    logic [CW-1:0] in_cnt, out_cnt, drop_cnt;
    logic [WW-1:0] w_cnt;
    logic [RW-1:0] r_cnt;

    logic empty, full, pop, push, drop, extra, in_capt, start_go;
    logic [CW:0] retired_next;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && out_ready;
    assign in_capt  = (state_q == CAPT);
    // A full FIFO still accepts the word when the consumer frees a slot this cycle.
    assign push     = in_capt && in_valid && (!full || pop);
    assign drop     = in_capt && in_valid && full && !pop;
    assign extra    = in_valid && !in_capt;
    assign start_go = (state_q == IDLE) && start;

    // Words accounted for once this cycle's handshake lands: delivered plus dropped.
    assign retired_next = {1'b0, out_cnt} + {1'b0, drop_cnt} + {{CW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CAPT;
            CAPT:    if (in_valid && (in_cnt == TOTAL_M1)) state_d = DRAIN;
            DRAIN:   if (retired_next == TOTAL_X) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        out_valid   = !empty;
        out_data    = mem_data[rd_ptr[AW-1:0]];
        out_last    = !empty && mem_last[rd_ptr[AW-1:0]];
        out_replica = empty ? '0 : mem_rep[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= in_data;
            mem_last[wr_ptr[AW-1:0]] <= (w_cnt == W_LAST);
            mem_rep[wr_ptr[AW-1:0]]  <= r_cnt;
        end
    end

    // Position tags advance on every counted word, dropped or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            drop_cnt  <= '0;
            w_cnt     <= '0;
            r_cnt     <= '0;
            err_ovf   <= 1'b0;
            err_extra <= 1'b0;
        end else if (start_go) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            drop_cnt  <= '0;
            w_cnt     <= '0;
            r_cnt     <= '0;
            err_ovf   <= 1'b0;
            err_extra <= 1'b0;
        end else begin
            if (in_capt && in_valid) begin
                in_cnt <= in_cnt + CW'(1);
                if (w_cnt == W_LAST) begin
                    w_cnt <= '0;
                    r_cnt <= r_cnt + RW'(1);
                end else begin
                    w_cnt <= w_cnt + WW'(1);
                end
            end
            if (pop) out_cnt <= out_cnt + CW'(1);
            if (drop) begin
                drop_cnt <= drop_cnt + CW'(1);
                err_ovf  <= 1'b1;
            end
            if (extra) err_extra <= 1'b1;
        end
    end

endmodule

// File: tb/tb_replica_unloader.sv
// Self-checking bench for replica_unloader: directed table, hand-written corner
// sequences and randomized runs against a queue-based reference model.
module tb_replica_unloader;

    localparam int LANES       = 8;
    localparam int LANE_W      = 7;
    localparam int CITY_NUM    = 16;
    localparam int REPLICA_NUM = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int DW          = LANES * LANE_W;
    localparam int RW          = 2;
    localparam int TOTAL       = REPLICA_NUM * CITY_NUM;

    logic clk = 1'b0;
    logic reset, start, in_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic out_valid, out_last, busy, done, err_ovf, err_extra;
    logic [RW-1:0] out_replica;

    always #5 clk = ~clk;

    replica_unloader #(
        .LANES(LANES), .LANE_W(LANE_W), .CITY_NUM(CITY_NUM),
        .REPLICA_NUM(REPLICA_NUM), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_replica(out_replica),
        .busy(busy), .done(done), .err_ovf(err_ovf), .err_extra(err_extra)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [RW-1:0] rep;
    } item_t;

    typedef struct {
        bit st, iv, rdy;
        bit e_busy, e_valid, e_extra, e_done;
    } vec_t;

    // Reference model: phase 0..3 = idle/capture/drain/done, FIFO as a queue.
    item_t q[$];
    int m_phase, m_in, m_hs, m_drop;
    bit m_ovf, m_extra;

    int chk_cnt = 0, pass_cnt = 0;
    int hs_seen, last_seen;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] lane_word(int k);
        logic [DW-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = LANE_W'(k * 8 + i);
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic model_step(bit rst, bit st, bit iv, logic [DW-1:0] d, bit rdy);
        bit pop, pend;
        item_t it;
        if (rst) begin
            q.delete();
            m_phase = 0; m_in = 0; m_hs = 0; m_drop = 0; m_ovf = 0; m_extra = 0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        pend = 0;
        case (m_phase)
            0: if (st) begin
                   m_phase = 1; m_in = 0; m_hs = 0; m_drop = 0; m_ovf = 0; m_extra = 0;
               end else if (iv) m_extra = 1;
            1: if (iv) begin
                   if (q.size() < FIFO_DEPTH || pop) begin
                       it.data = d;
                       it.last = ((m_in % CITY_NUM) == CITY_NUM - 1);
                       it.rep  = RW'(m_in / CITY_NUM);
                       pend    = 1;
                   end else begin
                       m_drop++;
                       m_ovf = 1;
                   end
                   m_in++;
                   if (m_in == TOTAL) m_phase = 2;
               end
            2: begin
                   if (iv) m_extra = 1;
                   if (m_hs + m_drop + (pop ? 1 : 0) == TOTAL) m_phase = 3;
               end
            default: begin
                   if (iv) m_extra = 1;
                   m_phase = 0;
               end
        endcase
        if (pop) begin
            void'(q.pop_front());
            m_hs++;
        end
        if (pend) q.push_back(it);
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_last", out_last, q[0].last);
            check("out_replica", out_replica, q[0].rep);
        end
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 3);
        check("err_ovf", err_ovf, m_ovf);
        check("err_extra", err_extra, m_extra);
    endtask

    task automatic cyc(bit rst, bit st, bit iv, logic [DW-1:0] d, bit rdy);
        reset = rst; start = st; in_valid = iv; in_data = d; out_ready = rdy;
        if (!rst && out_valid && rdy) begin
            hs_seen++;
            if (out_last) last_seen++;
        end
        model_step(rst, st, iv, d, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_until_done(int budget, bit toggle);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc(0, 0, 0, '0, toggle ? n[0] : 1'b1);
            n++;
        end
        check("done_within_budget", done, 1);
        cyc(0, 0, 0, '0, 1);
    endtask

    task automatic clean_run();
        hs_seen = 0; last_seen = 0;
        cyc(0, 1, 0, '0, 1);
        for (int k = 0; k < TOTAL; k++) cyc(0, 0, 1, lane_word(k), 1);
        run_until_done(10, 0);
        check("clean_handshakes", hs_seen, TOTAL);
        check("clean_last_count", last_seen, REPLICA_NUM);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl = '{
            '{0, 0, 1, 0, 0, 0, 0},
            '{0, 1, 1, 0, 0, 1, 0},
            '{1, 0, 1, 1, 0, 0, 0},
            '{0, 1, 0, 1, 1, 0, 0},
            '{1, 0, 1, 1, 0, 0, 0},
            '{0, 1, 1, 1, 1, 0, 0}
        };
        hs_seen = 0; last_seen = 0;
        reset = 1; start = 0; in_valid = 0; out_ready = 0; in_data = '0;

        cyc(1, 0, 0, '0, 0);
        cyc(1, 0, 0, '0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_replica", out_replica, 0);
        check("rst_busy", busy, 0);

        // Idle extra word, start, capture, start ignored mid-capture.
        for (int i = 0; i < 6; i++) begin
            cyc(0, tbl[i].st, tbl[i].iv, lane_word(i), tbl[i].rdy);
            check("tbl_busy", busy, tbl[i].e_busy);
            check("tbl_valid", out_valid, tbl[i].e_valid);
            check("tbl_extra", err_extra, tbl[i].e_extra);
            check("tbl_done", done, tbl[i].e_done);
        end
        for (int k = 2; k < TOTAL; k++) cyc(0, (k == 30), 1, lane_word(k), 1);
        run_until_done(10, 0);
        check("seq_err_ovf", err_ovf, 0);
        check("seq_err_extra", err_extra, 0);

        clean_run();

        // Consumer stalled for the whole capture: 16 kept, 48 dropped.
        hs_seen = 0;
        cyc(0, 1, 0, '0, 0);
        for (int k = 0; k < TOTAL; k++) cyc(0, 0, 1, lane_word(k), 0);
        check("stall_err_ovf", err_ovf, 1);
        cyc(0, 0, 1, lane_word(99), 0);
        check("drain_err_extra", err_extra, 1);
        check("drain_busy", busy, 1);
        run_until_done(40, 0);
        check("stall_handshakes", hs_seen, FIFO_DEPTH);

        // Full FIFO with push and pop landing together.
        hs_seen = 0;
        cyc(0, 1, 0, '0, 0);
        for (int k = 0; k < FIFO_DEPTH; k++) cyc(0, 0, 1, lane_word(k), 0);
        for (int k = FIFO_DEPTH; k < TOTAL; k++) begin
            cyc(0, 0, 1, lane_word(k), 1);
            cyc(0, 0, 0, '0, 0);
        end
        check("full_err_ovf", err_ovf, 0);
        run_until_done(60, 1);
        check("full_handshakes", hs_seen, TOTAL);

        // Reset mid-capture, then a fresh capture.
        cyc(0, 1, 0, '0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 1, lane_word(k), 0);
        cyc(1, 0, 0, '0, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        clean_run();

        // Randomized runs with varying backpressure.
        for (int run = 0; run < 8; run++) begin
            int n = 0;
            if ($urandom_range(0, 1) == 1) cyc(0, 0, 1, rand_word(), 1);
            cyc(0, 1, 0, '0, $urandom_range(0, 1) == 1);
            while (done !== 1'b1 && n < 1000) begin
                cyc(0, 0, $urandom_range(0, 3) != 0, rand_word(),
                    $urandom_range(0, run % 4 + 1) != 0);
                n++;
            end
            check("rand_done_within_budget", done, 1);
            cyc(0, 0, 0, '0, 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
